unidade_de_busca: RTL and testbench

Instruction fetch and sequencing unit for the single-cycle-decode core. Holds the program counter, fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake, and presents the opcode/opex fields to the control unit. It consumes the resolved jump/branch/stack outcome back from the execute side to select the next PC, and maintains a hardware return-address stack for call/return.

---
 rtl/unidade_de_busca.sv | 186 ++++++++++++++++++
 tb/tb_unidade_de_busca.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_de_busca.sv
// unidade_de_busca -- instruction fetch and sequencing unit.
//
// Holds the program counter and fetches 32-bit words from instruction memory
// over a request/acknowledge handshake. Each latched instruction is presented
// to the control unit. The resolved jump/branch/call/return outcome that comes
// back from execute selects the next PC. A hardware return-address stack
// supports call/return.
//
// Handshake semantics:
//   imem_req/imem_ack  : imem_req is high for every cycle in FETCH.
//                        imem_addr is held stable until a cycle with imem_ack=1
//                        completes the fetch. imem_ack is ignored in all other
//                        states, and an ack in the same cycle imem_req rises is
//                        legal.
//   instr_valid/ctrl_ack : instr_valid is high for every cycle in ISSUE.
//                        instr, opcode, opex and pc_atual are held stable.
//                        The cycle with ctrl_ack=1 consumes the instruction,
//                        and salto/desvio/cond/empilha/desempilha/alvo are
//                        sampled in that same cycle. They are ignored in all
//                        other cycles.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   imem_addr/req/ack/data instruction memory fetch port
//   instr, opcode, opex,  latched instruction and fields, address it came from
//   pc_atual
//   instr_valid, ctrl_ack issue handshake to/from execute
//   salto, desvio, cond,  control-flow outcome for the issued instruction
//   empilha, desempilha,
//   alvo
//   pilha_vazia/cheia     registered return-stack occupancy flags
//   erro_pilha            sticky stack overflow/underflow flag
//   parado                HALT word fetched; only reset leaves this state
//   estado                current FSM state (debug observation)

module unidade_de_busca #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        opex,
    output logic [ADDR_W-1:0] pc_atual,
    output logic              instr_valid,
    input  logic              ctrl_ack,
    input  logic              salto,
    input  logic              desvio,
    input  logic              cond,
    input  logic              empilha,
    input  logic              desempilha,
    input  logic [ADDR_W-1:0] alvo,
    output logic              pilha_vazia,
    output logic              pilha_cheia,
    output logic              erro_pilha,
    output logic              parado,
    output logic [1:0]        estado
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    // One extra bit so that "full" (sp == STACK_DEPTH) is representable.
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0]   SP_CHEIO = SP_W'(STACK_DEPTH);
    localparam logic [31:0]       PALAVRA_HALT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } estado_t;

    estado_t           est, est_prox;
    logic [ADDR_W-1:0] pc, pc_prox, pc_inc;
    logic [SP_W-1:0]   sp, sp_prox;
    logic              erro_prox;
    logic              carrega;    // latch imem_data / pc into instr / pc_atual
    logic              push;       // write return address at stack[sp]
    logic [IDX_W-1:0]  idx_push;
    logic [IDX_W-1:0]  idx_topo;

    logic [ADDR_W-1:0] pilha [STACK_DEPTH];

    // pc+1 doubles as the return address, and both wrap at 2^ADDR_W.
    assign pc_inc   = pc + ADDR_W'(1);
    assign idx_push = sp[IDX_W-1:0];
    assign idx_topo = IDX_W'(sp - SP_W'(1));

    // Next-state and next-PC selection.
    always_comb begin
        est_prox  = est;
        pc_prox   = pc;
        sp_prox   = sp;
        erro_prox = erro_pilha;
        carrega   = 1'b0;
        push      = 1'b0;
        case (est)
            IDLE: est_prox = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    carrega  = 1'b1;
                    est_prox = (imem_data == PALAVRA_HALT) ? HALT : ISSUE;
                end
            end
            ISSUE: begin
                if (ctrl_ack) begin
                    est_prox = FETCH;
                    // Priority: return > call > jump > taken branch > sequential.
                    if (desempilha) begin
                        if (sp != '0) begin
                            sp_prox = sp - SP_W'(1);
                            pc_prox = pilha[idx_topo];
                        end else begin
                            erro_prox = 1'b1;
                            pc_prox   = pc_inc;
                        end
                    end else if (empilha) begin
                        // A call on a full stack still jumps, but it loses the
                        // return address and raises the error flag.
                        if (sp != SP_CHEIO) begin
                            push    = 1'b1;
                            sp_prox = sp + SP_W'(1);
                        end else begin
                            erro_prox = 1'b1;
                        end
                        pc_prox = alvo;
                    end else if (salto || (desvio && cond)) begin
                        pc_prox = alvo;
                    end else begin
                        pc_prox = pc_inc;
                    end
                end
            end
            HALT: est_prox = HALT;
            default: est_prox = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            est         <= IDLE;
            pc          <= ADDR_W'(RESET_PC);
            sp          <= '0;
            erro_pilha  <= 1'b0;
            instr       <= '0;
            pc_atual    <= '0;
            pilha_vazia <= 1'b1;
            pilha_cheia <= 1'b0;
        end else begin
            est         <= est_prox;
            pc          <= pc_prox;
            sp          <= sp_prox;
            erro_pilha  <= erro_prox;
            // Flags are computed from the next sp, so they change in the
            // same cycle as sp does.
            pilha_vazia <= (sp_prox == '0);
            pilha_cheia <= (sp_prox == SP_CHEIO);
            if (carrega) begin
                instr    <= imem_data;
                pc_atual <= pc;
            end
        end
    end

    // Stack storage needs no reset: entries are only read below sp.
    always_ff @(posedge clock) begin
        if (push) begin
            pilha[idx_push] <= pc_inc;
        end
    end

    assign imem_addr   = pc;
    assign imem_req    = (est == FETCH);
    assign instr_valid = (est == ISSUE);
    assign parado      = (est == HALT);
    assign opcode      = instr[31:26];
    assign opex        = instr[5:0];
    assign estado      = est;

endmodule

// File: tb/tb_unidade_de_busca.sv
// tb_unidade_de_busca -- self-checking bench for unidade_de_busca.
//
// Purpose: drives the fetch and issue handshakes against a behavioural model.
// The model holds the PC, the return stack (a queue) and the error flag, and
// predicts each issued instruction and the next PC.
//
// DUT ports: all ports of unidade_de_busca are connected, including the
// estado debug output.
//
// The driver acts as instruction memory and as the execute stage. When it
// acknowledges a fetch, it pushes the expected {pc, word} into exp_q. A
// separate monitor pops and compares each time a new instruction is issued.

module tb_unidade_de_busca;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 8;
    localparam logic [ADDR_W-1:0] RST_PC = '0;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    // Clock and reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [31:0]       imem_data;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [5:0]        opex;
    logic [ADDR_W-1:0] pc_atual;
    logic              instr_valid;
    logic              ctrl_ack;
    logic              salto;
    logic              desvio;
    logic              cond;
    logic              empilha;
    logic              desempilha;
    logic [ADDR_W-1:0] alvo;
    logic              pilha_vazia;
    logic              pilha_cheia;
    logic              erro_pilha;
    logic              parado;
    logic [1:0]        estado;

    unidade_de_busca #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_data(imem_data), .instr(instr), .opcode(opcode), .opex(opex),
        .pc_atual(pc_atual), .instr_valid(instr_valid), .ctrl_ack(ctrl_ack),
        .salto(salto), .desvio(desvio), .cond(cond), .empilha(empilha),
        .desempilha(desempilha), .alvo(alvo), .pilha_vazia(pilha_vazia),
        .pilha_cheia(pilha_cheia), .erro_pilha(erro_pilha), .parado(parado),
        .estado(estado)
    );

    // Model and scoreboard
    logic [31:0]       mem [1 << ADDR_W];
    logic [ADDR_W+31:0] exp_q [$];
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_stack [$];
    logic              m_err;
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Outcome bits: {desempilha, empilha, salto, desvio, cond}
    task automatic model_apply(input logic [4:0] oc, input logic [ADDR_W-1:0] a);
        if (oc[4]) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_err = 1'b1; m_pc = m_pc + 1'b1; end
        end else if (oc[3]) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 1'b1);
            else m_err = 1'b1;
            m_pc = a;
        end else if (oc[2] || (oc[1] && oc[0])) begin
            m_pc = a;
        end else begin
            m_pc = m_pc + 1'b1;
        end
    endtask

    // Monitor: one pop per issued instruction (rising edge of instr_valid).
    logic prev_valid = 1'b0;
    always @(negedge clock) begin
        logic [ADDR_W+31:0] e;
        if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL issue_unexpected: instr_valid rose with empty queue, pc_atual=%0h", pc_atual);
            end else begin
                e = exp_q.pop_front();
                check("pc_atual", pc_atual, e[ADDR_W+31:32]);
                check("instr", instr, e[31:0]);
                check("opcode", opcode, e[31:26]);
                check("opex", opex, e[5:0]);
            end
        end
        prev_valid = instr_valid;
    end

    // Driver tasks
    task automatic scramble_outcome();
        {desempilha, empilha, salto, desvio, cond} = 5'($urandom);
        alvo = ADDR_W'($urandom);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        imem_ack = 1'b0; ctrl_ack = 1'b0; imem_data = '0;
        scramble_outcome();
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_opcode", opcode, 0);
        check("rst_opex", opex, 0);
        check("rst_pc_atual", pc_atual, 0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_vazia", pilha_vazia, 1);
        check("rst_cheia", pilha_cheia, 0);
        check("rst_erro", erro_pilha, 0);
        check("rst_parado", parado, 0);
        m_pc = RST_PC;
        m_stack.delete();
        m_err = 1'b0;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        check("idle_req", imem_req, 0);
        @(negedge clock);
        check("req_after_reset", imem_req, 1);
    endtask

    // Completes one fetch after fd stall cycles. It returns with the DUT in
    // ISSUE or HALT.
    task automatic fetch_part(input int fd, output bit ok, output logic [31:0] w);
        ok = 1'b0;
        w  = '0;
        check("fetch_req", imem_req, 1);
        if (!imem_req) return;
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < fd; i++) begin
            // Outcome inputs and ctrl_ack must be ignored while fetching.
            ctrl_ack  = 1'($urandom);
            scramble_outcome();
            imem_ack  = 1'b0;
            imem_data = $urandom;
            @(negedge clock);
            check("stall_addr", imem_addr, m_pc);
            check("stall_req", imem_req, 1);
            check("stall_valid", instr_valid, 0);
        end
        w = mem[m_pc];
        imem_ack  = 1'b1;
        imem_data = w;
        ctrl_ack  = 1'($urandom);
        if (w != HALT_W) exp_q.push_back({m_pc, w});
        @(negedge clock);
        imem_ack  = 1'b0;
        ctrl_ack  = 1'b0;
        imem_data = $urandom;
        ok = 1'b1;
    endtask

    task automatic issue_part(input logic [4:0] oc, input logic [ADDR_W-1:0] a, input int cd);
        check("issue_valid", instr_valid, 1);
        for (int i = 0; i < cd; i++) begin
            scramble_outcome();
            imem_ack  = 1'($urandom);
            imem_data = HALT_W;
            @(negedge clock);
            check("wait_valid", instr_valid, 1);
            check("wait_req", imem_req, 0);
            check("wait_addr", imem_addr, m_pc);
        end
        imem_ack = 1'b0;
        {desempilha, empilha, salto, desvio, cond} = oc;
        alvo     = a;
        ctrl_ack = 1'b1;
        @(negedge clock);
        ctrl_ack = 1'b0;
        scramble_outcome();
        model_apply(oc, a);
        check("pilha_vazia", pilha_vazia, m_stack.size() == 0);
        check("pilha_cheia", pilha_cheia, m_stack.size() == DEPTH);
        check("erro_pilha", erro_pilha, m_err);
    endtask

    task automatic step(input logic [4:0] oc, input logic [ADDR_W-1:0] a, input int fd, input int cd);
        bit ok;
        logic [31:0] w;
        fetch_part(fd, ok, w);
        if (!ok) return;
        if (w == HALT_W) begin
            check("halt_parado", parado, 1);
            return;
        end
        issue_part(oc, a, cd);
    endtask

    localparam logic [4:0] SEQ = 5'b00000, POP = 5'b10000, CALL = 5'b01000,
                           JMP = 5'b00100, BR_NT = 5'b00010, BR_T = 5'b00011;

    // Stimulus
    initial begin
        bit ok;
        logic [31:0] w;
        imem_ack = 1'b0; imem_data = '0; ctrl_ack = 1'b0;
        salto = 1'b0; desvio = 1'b0; cond = 1'b0; empilha = 1'b0; desempilha = 1'b0;
        alvo = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT_W) mem[i] = 32'h1234_5678;
        end
        do_reset();

        // Back-to-back sequential 0..4, then branch, jump and call/return.
        for (int i = 0; i < 5; i++) step(SEQ, '0, 0, 0);
        step(BR_NT, 10'd77, 0, 0);          // pc 5 -> 6
        step(BR_T, 10'd40, 0, 0);           // pc 6 -> 40
        step(JMP | BR_NT, 10'd12, 0, 0);    // pc 40 -> 12
        step(CALL, 10'd100, 0, 0);          // pc 12 -> 100, push 13
        step(POP, 10'd300, 0, 0);           // pc 100 -> 13
        step(SEQ, '0, 3, 2);                // stalls on both handshakes

        // Nine nested calls overflow; nine returns end in an underflow.
        for (int i = 0; i < 9; i++) step(CALL, ADDR_W'(200 + i * 3), 0, 0);
        for (int i = 0; i < 9; i++) step(POP, '0, 0, 0);

        // PC and return-address wrap.
        step(JMP, 10'd1023, 0, 0);
        step(SEQ, '0, 0, 0);                // 1023 -> 0
        step(JMP, 10'd1023, 0, 0);
        step(CALL, 10'd50, 1, 1);           // pushes 0
        step(POP, '0, 0, 0);                // back to 0

        // Randomized traffic, from a clean reset so the stack is usable again.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            logic [4:0] oc;
            case ($urandom_range(0, 9))
                0, 1:    oc = SEQ;
                2:       oc = {3'b000, 1'b1, 1'($urandom)};
                3:       oc = JMP;
                4, 5:    oc = CALL;
                6, 7:    oc = POP;
                default: oc = 5'($urandom);
            endcase
            step(oc, ADDR_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset while an instruction is being issued.
        fetch_part(1, ok, w);
        do_reset();
        step(SEQ, '0, 0, 0);

        // HALT word at address 3.
        mem[3] = HALT_W;
        do_reset();
        for (int i = 0; i < 3; i++) step(SEQ, '0, 0, 0);
        fetch_part(0, ok, w);
        check("halt_reached", ok && (w == HALT_W), 1);
        for (int i = 0; i < 6; i++) begin
            imem_ack = 1'($urandom);
            ctrl_ack = 1'($urandom);
            scramble_outcome();
            @(negedge clock);
            check("halt_parado", parado, 1);
            check("halt_req", imem_req, 0);
            check("halt_valid", instr_valid, 0);
        end
        do_reset();
        check("restart_parado", parado, 0);
        step(SEQ, '0, 0, 0);
        step(SEQ, '0, 0, 0);

        repeat (2) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
